// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the 7-segment scan controller.
// Sizes the phase timer and the digit index from the configured parameters.
package seg_scan_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    localparam logic [3:0] CODE_BLANK = 4'hF;

    // ceil(log2(n)), never below 1 so a 1-cycle phase still has a real counter bit
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Terminal-count phase timer: counts 0..last_i and wraps to 0 on the terminal cycle.
// The terminal value is an input so one counter serves both BLANK and SHOW phases.
module seg_scan_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] last_i,
    output logic         tc_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         at_last;

    assign at_last = (count_q == last_i);
    assign tc_o    = en_i && !clr_i && at_last;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = at_last ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with double-buffered digit codes.
// Each slot is a dark BLANK gap followed by a SHOW phase driving one active-low anode.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int SHOW_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    output logic [3:0]              code,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    import seg_scan_pkg::*;

    localparam int TW = cnt_width(max_int(SHOW_CYCLES, BLANK_CYCLES));
    localparam int IW = cnt_width(NUM_DIGITS);

    localparam logic [TW-1:0] SHOW_LAST  = TW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    scan_state_t state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic run_q;

    logic                    pending_q, pending_d;
    logic [4*NUM_DIGITS-1:0] stage_code_q, stage_code_d;
    logic [NUM_DIGITS-1:0]   stage_en_q, stage_en_d;
    logic [4*NUM_DIGITS-1:0] shadow_code_q, shadow_code_d;
    logic [NUM_DIGITS-1:0]   shadow_en_q, shadow_en_d;

    logic [3:0]            code_q, code_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [3:0]            shadow_arr [NUM_DIGITS];

    logic          scanning;
    logic          timer_tc;
    logic [TW-1:0] timer_last;

    // run_q delays scanning by one cycle after enable rises, so the first BLANK
    // of digit 0 is spent with its code already on the transcoder.
    assign scanning   = enable && run_q;
    assign timer_last = (state_q == SHOW) ? SHOW_LAST : BLANK_LAST;

    seg_scan_timer #(
        .W (TW)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (!enable),
        .en_i   (scanning),
        .last_i (timer_last),
        .tc_o   (timer_tc)
    );

    assign frame_done = timer_tc && (state_q == SHOW) && (idx_q == IDX_LAST);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (!scanning) begin
            state_d = BLANK;
            idx_d   = '0;
        end else if (timer_tc) begin
            if (state_q == BLANK) begin
                state_d = SHOW;
            end else begin
                state_d = BLANK;
                idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end
        end
    end

    // Shadow only moves on the frame boundary, so a frame never mixes old and new digits.
    always_comb begin
        pending_d     = pending_q;
        stage_code_d  = stage_code_q;
        stage_en_d    = stage_en_q;
        shadow_code_d = shadow_code_q;
        shadow_en_d   = shadow_en_q;
        if (load) begin
            stage_code_d = digits;
            stage_en_d   = digit_en;
            pending_d    = 1'b1;
        end
        if (frame_done) begin
            if (load) begin
                shadow_code_d = digits;
                shadow_en_d   = digit_en;
                pending_d     = 1'b0;
            end else if (pending_q) begin
                shadow_code_d = stage_code_q;
                shadow_en_d   = stage_en_q;
                pending_d     = 1'b0;
            end
        end
    end

    // Outputs are registered from next-state values so they line up with state_q.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign shadow_arr[gi] = shadow_code_d[4*gi +: 4];
            assign an_d[gi] = !(enable && (state_d == SHOW) &&
                                (idx_d == IW'(gi)) && shadow_en_d[gi]);
        end
    endgenerate

    always_comb begin
        code_d = CODE_BLANK;
        if (enable && shadow_en_d[idx_d]) begin
            code_d = shadow_arr[idx_d];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= BLANK;
            idx_q         <= '0;
            run_q         <= 1'b0;
            pending_q     <= 1'b0;
            stage_code_q  <= {NUM_DIGITS{CODE_BLANK}};
            stage_en_q    <= '0;
            shadow_code_q <= {NUM_DIGITS{CODE_BLANK}};
            shadow_en_q   <= '0;
            code_q        <= CODE_BLANK;
            an_q          <= '1;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            run_q         <= enable;
            pending_q     <= pending_d;
            stage_code_q  <= stage_code_d;
            stage_en_q    <= stage_en_d;
            shadow_code_q <= shadow_code_d;
            shadow_en_q   <= shadow_en_d;
            code_q        <= code_d;
            an_q          <= an_d;
        end
    end

    assign code = code_q;
    assign an   = an_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a 4-digit, 1+4 cycle slot configuration.
// Expected codes/anodes come from hand-chosen digit words and enable masks.
module tb_seg_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [15:0] digits;
    logic [3:0]  digit_en;
    logic        load;
    logic [3:0]  code;
    logic [3:0]  an;
    logic        frame_done;

    int total;
    int bad;

    seg_scan_ctrl #(
        .NUM_DIGITS   (4),
        .SHOW_CYCLES  (4),
        .BLANK_CYCLES (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .digits     (digits),
        .digit_en   (digit_en),
        .load       (load),
        .code       (code),
        .an         (an),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_fd(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            load = 1'b0;
            n = n + 1;
        end while (frame_done !== 1'b1 && n < budget);
        check_val(tag, 32'(frame_done), 32'd1);
    endtask

    // Checks one 20-cycle frame starting at the slot-0 BLANK cycle; optional loads
    // are driven at frame cycles la and lb (-1 = none).
    task automatic check_frame(input string name, input logic [15:0] dig, input logic [3:0] en,
                               input int la, input logic [15:0] ld, input logic [3:0] le,
                               input int lb, input logic [15:0] md, input logic [3:0] me);
        int s;
        int k;
        logic [3:0] ec;
        logic [3:0] ea;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            s  = c / 5;
            k  = c % 5;
            ec = en[s] ? dig[4*s +: 4] : 4'hF;
            ea = (k != 0 && en[s]) ? ~(4'b0001 << s) : 4'b1111;
            check_val($sformatf("%s c%0d code", name, c), 32'(code), 32'(ec));
            check_val($sformatf("%s c%0d an", name, c), 32'(an), 32'(ea));
            check_val($sformatf("%s c%0d frame_done", name, c), 32'(frame_done), 32'(c == 19));
            $display("%s cycle %0d: code=%h an=%b fd=%b", name, c, code, an, frame_done);
            load = 1'b0;
            if (c == la) begin
                load = 1'b1; digits = ld; digit_en = le;
            end
            if (c == lb) begin
                load = 1'b1; digits = md; digit_en = me;
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; enable = 1'b0; load = 1'b0; digits = '0; digit_en = '0;

        @(negedge clk);
        check_val("rst code", 32'(code), 32'hF);
        check_val("rst an", 32'(an), 32'hF);
        check_val("rst frame_done", 32'(frame_done), 32'd0);
        check_val("rst pending", 32'(dut.pending_q), 32'd0);
        rst = 1'b0;
        digits = 16'h3210; digit_en = 4'b1111; load = 1'b1;

        @(negedge clk);
        load = 1'b0;
        check_val("load pending", 32'(dut.pending_q), 32'd1);
        check_val("pre-enable code", 32'(code), 32'hF);
        enable = 1'b1;

        wait_fd("first fd", 60);
        check_frame("fA", 16'h3210, 4'b1111, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        // two mid-frame loads: current frame untouched, last load wins next frame
        check_frame("fB", 16'h3210, 4'b1111, 3, 16'h0000, 4'h0, 12, 16'hC9A5, 4'b1111);
        check_frame("fC", 16'hC9A5, 4'b1111, 7, 16'h3210, 4'b1011, -1, 16'h0, 4'h0);
        check_frame("fD", 16'h3210, 4'b1011, 8, 16'h1234, 4'b1111, 19, 16'h5678, 4'b0111);
        check_frame("fE", 16'h5678, 4'b0111, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        check_val("fE pending", 32'(dut.pending_q), 32'd0);
        check_frame("fF", 16'h5678, 4'b0111, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

        // run to slot 2 SHOW, then drop enable and load while dark
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            load = 1'b0;
        end
        check_val("slot2 show an", 32'(an), 32'b1011);
        check_val("slot2 show code", 32'(code), 32'h6);
        enable = 1'b0;
        load = 1'b1; digits = 16'h4321; digit_en = 4'b1111;

        @(negedge clk);
        load = 1'b0;
        check_val("dis an", 32'(an), 32'hF);
        check_val("dis code", 32'(code), 32'hF);
        check_val("dis frame_done", 32'(frame_done), 32'd0);
        $display("disabled: code=%h an=%b", code, an);
        @(negedge clk);
        check_val("dis2 an", 32'(an), 32'hF);
        check_val("dis2 code", 32'(code), 32'hF);
        check_val("dis pending", 32'(dut.pending_q), 32'd1);
        enable = 1'b1;

        @(negedge clk);
        check_val("reen blank an", 32'(an), 32'hF);
        check_val("reen blank code", 32'(code), 32'h8);
        @(negedge clk);
        check_val("reen show an", 32'(an), 32'b1110);
        check_val("reen show code", 32'(code), 32'h8);
        $display("re-enabled: code=%h an=%b", code, an);

        wait_fd("reen fd", 60);
        check_frame("fG", 16'h4321, 4'b1111, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

        // asynchronous reset landing in the middle of a SHOW cycle
        @(negedge clk);
        @(negedge clk);
        check_val("pre-rst an", 32'(an), 32'b1110);
        #2 rst = 1'b1;
        #1;
        check_val("async rst code", 32'(code), 32'hF);
        check_val("async rst an", 32'(an), 32'hF);
        check_val("async rst frame_done", 32'(frame_done), 32'd0);
        $display("async reset: code=%h an=%b fd=%b", code, an, frame_done);
        @(negedge clk);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the parking-system 7-segment display bank. It sequences NUM_DIGITS digit positions through one shared 4-bit-to-7-segment transcoder, driving the transcoder code and the active-low digit anodes.
- Double-buffers incoming digit values so a displayed frame never tears.
- Inserts a blanking gap between digits to suppress ghosting.
- Sits between the occupancy/counter logic and the board display pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digit positions (2..8)
SHOW_CYCLES, 100000, clock cycles each digit's anode is asserted (>=1)
BLANK_CYCLES, 1000, clock cycles of all-anodes-off gap before each digit (>=1)

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous reset, active-high
enable  input  1  1 = scanning runs; 0 = display dark, scan held
digits  input  4*NUM_DIGITS  packed digit codes, digit i at [4i+3:4i]; codes 0..12 are valid transcoder symbols, 13..15 display blank
digit_en  input  NUM_DIGITS  per-digit enable mask, sampled together with digits
load  input  1  one-cycle strobe: capture digits/digit_en for the next frame
code  output  4  code driven into the shared transcoder
an  output  NUM_DIGITS  digit anodes, active-low (0 = lit)
frame_done  output  1  one-cycle pulse on the last SHOW cycle of digit NUM_DIGITS-1

Behaviour:
- Reset (asynchronous, active-high). All of the following take these values immediately and hold them while rst=1:
  - state=BLANK, digit index=0, timer=0
  - pending=0, shadow codes=4'hF, shadow enables=0
  - code=4'hF, an=all ones, frame_done=0
- FSM has two states, BLANK and SHOW. One slot = BLANK_CYCLES + SHOW_CYCLES cycles. One frame = NUM_DIGITS slots.
- BLANK state:
  - an=all ones.
  - code = shadow code of the current index, or 4'hF if that digit is disabled.
  - Timer counts 0..BLANK_CYCLES-1, then the FSM moves to SHOW with timer=0.
- SHOW state:
  - an[idx]=0 only if shadow enable[idx]=1; all other anodes are 1.
  - code is unchanged from BLANK.
  - Timer counts 0..SHOW_CYCLES-1. On the terminal count: FSM returns to BLANK, idx increments, and idx wraps NUM_DIGITS-1 -> 0.
- Code changes only on BLANK entry. An anode is never low while code is changing.
- frame_done: asserted combinationally from registered state on the terminal SHOW cycle when idx=NUM_DIGITS-1; exactly one pulse per frame.
- Load / double-buffer:
  - load=1 captures digits and digit_en into a staging register and sets pending=1.
  - Shadow registers update from staging on the frame_done cycle if pending=1; pending is then cleared.
  - load on the frame_done cycle itself takes the input values directly into the shadow, and pending stays 0.
  - Multiple loads within one frame: the last one wins.
- enable=0:
  - Synchronously forces state=BLANK, idx=0, timer=0, an=all ones, code=4'hF, frame_done=0.
  - Staging and pending are still updated by load.
  - On enable 0->1, scanning starts at digit 0 BLANK. The next frame_done applies any pending load.
- Width rules:
  - Timer width = clog2(max(SHOW_CYCLES, BLANK_CYCLES)).
  - idx width = clog2(NUM_DIGITS).
  - All counters wrap exactly at their terminal counts, with no off-by-one.

Decomposition:
- Package seg_scan_pkg:
  - typedef scan_state_t {BLANK, SHOW}
  - localparam CODE_BLANK = 4'hF
  - function for the counter widths
- One natural sub-module, seg_scan_timer: a parameterised terminal-count timer with clear and enable, reused for both the BLANK and SHOW phases.
- The transcoder is instantiated at the top level, outside this block.

Test Plan (NUM_DIGITS=4, SHOW_CYCLES=4, BLANK_CYCLES=1; slot=5 cycles, frame=20 cycles):
- Reset mid-SHOW: assert rst asynchronously between clock edges -> code=4'hF, an=4'b1111, frame_done=0 before the next clk edge.
- Full scan: load digits=16'h3210, digit_en=4'b1111 once after reset, enable=1. After the load has taken effect:
  - per slot: code=0,1,2,3 in turn
  - an=1111 for 1 cycle, then 1110 / 1101 / 1011 / 0111 for 4 cycles each
  - frame_done pulses every 20 cycles
- Disabled digit: digit_en=4'b1011 -> during slot 2, code=4'hF and an stays 1111 for all 5 cycles; other slots are normal.
- Tear-free load: pulse load with digits=16'hC9A5 mid-frame -> the current frame still shows the old values; the new values appear starting with the slot-0 BLANK after frame_done.
- Load coincident with frame_done -> new values are shown in the very next frame and pending reads 0.
- enable dropped in slot 2 SHOW -> next cycle an=1111, code=4'hF. On re-enable, the first lit digit is idx 0 after 1 BLANK cycle.
